inst_fetch_queue: RTL

Instruction fetch front end that feeds the core's decode stage.
- Owns the program counter and issues word reads to instruction memory over a req/ack handshake.
- Buffers returned instructions with their PC in a small FIFO and presents them to decode over a valid/ready handshake.
- Handles jump redirects (Jen/Jin-style), flushing wrong-path instructions and discarding any in-flight wrong-path fetch.

---
 rtl/inst_fetch_queue.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/inst_fetch_queue.sv
// Instruction fetch front end: owns the fetch PC, issues word reads to
// instruction memory over req/ack, buffers {inst, pc} pairs in a small FIFO
// and hands them to decode over valid/ready. Jump redirects flush the FIFO
// and discard any wrong-path fetch that is still in flight.
//
// Handshakes: imem_req_o/imem_addr_o are held constant from the cycle req
// rises until the cycle imem_ack_i is seen (a transfer happens in any cycle
// with req && ack); a decode transfer happens in any cycle with
// dec_valid_o && dec_ready_i, and head outputs hold while valid && !ready.
module inst_fetch_queue #(
    parameter int              PC_W     = 9,
    parameter int              INST_W   = 32,
    parameter int              DEPTH    = 4,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req_o,
    output logic [PC_W-1:0]   imem_addr_o,
    input  logic              imem_ack_i,
    input  logic [INST_W-1:0] imem_rdata_i,
    input  logic              redirect_en_i,
    input  logic [PC_W-1:0]   redirect_pc_i,
    output logic              dec_valid_o,
    input  logic              dec_ready_i,
    output logic [INST_W-1:0] dec_inst_o,
    output logic [PC_W-1:0]   dec_pc_o,
    output logic [PC_W-1:0]   pcOUT_o,
    output logic              nop_o,
    output logic [15:0]       dec_count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_REQ     = 2'd1;
    localparam logic [1:0] S_DISCARD = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [PC_W-1:0]   stale_q, stale_d;
    logic [AW-1:0]     rd_q, rd_d;
    logic [AW-1:0]     wr_q, wr_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [CW-1:0]     cnt_next;
    logic [15:0]       dcnt_q, dcnt_d;
    logic [INST_W-1:0] mem_inst_q [DEPTH];
    logic [PC_W-1:0]   mem_pc_q   [DEPTH];

    logic push;
    logic pop;

    // Output decode; reset forces the idle/empty view even before state clears.
    always_comb begin
        imem_req_o  = (state_q != S_IDLE) && !rst;
        imem_addr_o = (state_q == S_DISCARD) ? stale_q : pc_q;
        dec_valid_o = (cnt_q != '0) && !redirect_en_i && !rst;
        dec_inst_o  = mem_inst_q[rd_q];
        dec_pc_o    = mem_pc_q[rd_q];
        pcOUT_o     = rst ? RESET_PC : pc_q;
        nop_o       = !dec_valid_o;
        dec_count_o = dcnt_q;
        push        = (state_q == S_REQ) && imem_ack_i && !redirect_en_i;
        pop         = dec_valid_o && dec_ready_i;
        cnt_next    = cnt_q + CW'(push) - CW'(pop);
    end

    // Next-state logic for the fetch FSM, PC, FIFO pointers and delivery count.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        stale_d = stale_q;
        rd_d    = pop  ? rd_q + AW'(1) : rd_q;
        wr_d    = push ? wr_q + AW'(1) : wr_q;
        cnt_d   = cnt_next;
        dcnt_d  = pop ? dcnt_q + 16'd1 : dcnt_q;

        if (redirect_en_i) begin
            // Flush wrong-path entries; the target becomes the new fetch PC.
            rd_d  = '0;
            wr_d  = '0;
            cnt_d = '0;
            pc_d  = redirect_pc_i;
        end

        case (state_q)
            S_IDLE: begin
                if (redirect_en_i || (cnt_q < CW'(DEPTH))) begin
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                if (redirect_en_i) begin
                    // An outstanding request must still complete at its old address.
                    if (!imem_ack_i) begin
                        state_d = S_DISCARD;
                        stale_d = pc_q;
                    end
                end else if (imem_ack_i) begin
                    pc_d    = pc_q + PC_W'(1);
                    state_d = (cnt_next < CW'(DEPTH)) ? S_REQ : S_IDLE;
                end
            end
            S_DISCARD: begin
                // The stale request finishing ends the discard, redirect or not.
                if (imem_ack_i) begin
                    state_d = (redirect_en_i || (cnt_next < CW'(DEPTH))) ? S_REQ : S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Control registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_PC;
            stale_q <= RESET_PC;
            rd_q    <= '0;
            wr_q    <= '0;
            cnt_q   <= '0;
            dcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            stale_q <= stale_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            cnt_q   <= cnt_d;
            dcnt_q  <= dcnt_d;
        end
    end

    // FIFO storage: write the returned instruction and its address at the tail.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            mem_inst_q[wr_q] <= imem_rdata_i;
            mem_pc_q[wr_q]   <= pc_q;
        end
    end

endmodule
